// File: rtl/sound_pkg.sv
// Shared melody-path definitions: note table, index encoding and decoder FSM states.
package sound_pkg;

  localparam int unsigned NUM_NOTES = 8;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned DUR_W     = 13;
  localparam int unsigned PERIOD_W  = 17;

  localparam logic [IDX_W-1:0] NOTE_IDX_NONE = 4'd15;

  localparam int unsigned NOTE_D     = 266;
  localparam int unsigned NOTE_E     = 237;
  localparam int unsigned NOTE_FIS   = 211;
  localparam int unsigned NOTE_G     = 199;
  localparam int unsigned NOTE_A     = 177;
  localparam int unsigned NOTE_B     = 158;
  localparam int unsigned NOTE_C     = 149;
  localparam int unsigned NOTE_DHIGH = 133;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic int unsigned note_table(input int unsigned i);
    case (i)
      0:       return NOTE_D;
      1:       return NOTE_E;
      2:       return NOTE_FIS;
      3:       return NOTE_G;
      4:       return NOTE_A;
      5:       return NOTE_B;
      6:       return NOTE_C;
      default: return NOTE_DHIGH;
    endcase
  endfunction

  function automatic logic pitch_close(input int unsigned a, input int unsigned b,
                                       input int unsigned tol);
    return ((a > b) ? (a - b) : (b - a)) <= tol;
  endfunction

  // Lowest table index within tolerance wins; scanning downwards leaves the first hit.
  function automatic logic [IDX_W-1:0] note_index(input int unsigned pitch, input int unsigned tol);
    logic [IDX_W-1:0] idx;
    idx = NOTE_IDX_NONE;
    for (int i = int'(NUM_NOTES) - 1; i >= 0; i--) begin
      if (pitch_close(pitch, note_table(i), tol)) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/clkgen.sv
// Free-running divider: one-cycle tick every maxval clk cycles.
module clkgen #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] maxval,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= maxval - WIDTH'(1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + WIDTH'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/note_decoder.sv
// Melody receive path: measures the sine period on pwm_pos/pwm_neg, locks on a note and
// emits one note event per finished tone. NOTE_DECODER_AVG_EN selects 4-period averaging.
module note_decoder
  import sound_pkg::*;
#(
  parameter int unsigned PITCH_BITWIDTH = 9,
  parameter int unsigned FS_MAXVAL      = 1250,
  parameter int unsigned LOCK_CNT       = 3,
  parameter int unsigned PITCH_TOL      = 2,
  parameter int unsigned TIMEOUT_CYC    = 80000,
  parameter int unsigned PERIOD_SHIFT   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pwm_pos,
  input  logic                      pwm_neg,
  output logic                      note_valid,
  output logic [PITCH_BITWIDTH-1:0] note_pitch,
  output logic [IDX_W-1:0]          note_idx,
  output logic [DUR_W-1:0]          note_duration,
  output logic                      tone_active
);

  localparam int unsigned PMAX  = (1 << PITCH_BITWIDTH) - 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SUM_W = PERIOD_W + 3;
`ifdef NOTE_DECODER_AVG_EN
  localparam int unsigned LOCK_EFF  = (LOCK_CNT > 4) ? LOCK_CNT : 4;
  localparam int unsigned AVG_SHIFT = PERIOD_SHIFT + 2;
`else
  localparam int unsigned LOCK_EFF  = LOCK_CNT;
  localparam int unsigned AVG_SHIFT = PERIOD_SHIFT;
`endif
  localparam int unsigned MATCH_W = $clog2(LOCK_EFF + 1);

  logic [2:0]                pos_sr, neg_sr;
  logic                      rise_pos, rise_neg, phase_pos, crossing, timeout, fs_tick;
  logic [PERIOD_W-1:0]       period_cnt;
  logic [TO_W-1:0]           to_cnt;
  logic [SUM_W-1:0]          period_sum, pitch_round;
  logic [PITCH_BITWIDTH-1:0] pitch, prev_pitch, prev_pitch_nxt, ref_pitch, ref_pitch_nxt;
  logic                      prev_valid, prev_valid_nxt, ev;
  logic [MATCH_W-1:0]        match_cnt, match_nxt, match_inc;
  logic [DUR_W-1:0]          dur_cnt, dur_nxt, dur_inc;
  state_t                    state, state_nxt;

  clkgen #(.WIDTH(11)) u_fs_clkgen (
    .clk    (clk),
    .reset  (reset),
    .maxval (11'(FS_MAXVAL)),
    .tick   (fs_tick)
  );

  // Two sync stages plus one history stage for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_sr    <= '0;
      neg_sr    <= '0;
      phase_pos <= 1'b0;
    end else begin
      pos_sr <= {pos_sr[1:0], pwm_pos};
      neg_sr <= {neg_sr[1:0], pwm_neg};
      if (rise_pos && !rise_neg)      phase_pos <= 1'b1;
      else if (rise_neg && !rise_pos) phase_pos <= 1'b0;
    end
  end

  assign rise_pos = pos_sr[1] & ~pos_sr[2];
  assign rise_neg = neg_sr[1] & ~neg_sr[2];
  assign crossing = ~phase_pos & rise_pos & ~rise_neg;
  assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYC - 1)) & ~crossing;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      to_cnt     <= '0;
    end else if (crossing) begin
      period_cnt <= PERIOD_W'(1);
      to_cnt     <= '0;
    end else begin
      if (period_cnt != '1)                 period_cnt <= period_cnt + PERIOD_W'(1);
      if (to_cnt != TO_W'(TIMEOUT_CYC))     to_cnt     <= to_cnt + TO_W'(1);
    end
  end

`ifdef NOTE_DECODER_AVG_EN
  logic [PERIOD_W-1:0] hist0, hist1, hist2;
  logic                first_sample;

  assign first_sample = (state == ST_ACQUIRE) && !prev_valid;
  assign period_sum   = first_sample ? (SUM_W'(period_cnt) << 2)
                      : SUM_W'(period_cnt) + SUM_W'(hist0) + SUM_W'(hist1) + SUM_W'(hist2);

  // History restarts from the current period whenever a new note acquisition begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
    end else if (crossing) begin
      if (first_sample || ev || state == ST_IDLE) begin
        hist0 <= period_cnt;
        hist1 <= period_cnt;
        hist2 <= period_cnt;
      end else begin
        hist0 <= period_cnt;
        hist1 <= hist0;
        hist2 <= hist1;
      end
    end
  end
`else
  assign period_sum = SUM_W'(period_cnt);
`endif

  assign pitch_round = (period_sum + (SUM_W'(1) << (AVG_SHIFT - 1))) >> AVG_SHIFT;
  assign pitch       = (pitch_round > SUM_W'(PMAX)) ? PITCH_BITWIDTH'(PMAX)
                                                    : PITCH_BITWIDTH'(pitch_round);
  assign match_inc   = match_cnt + MATCH_W'(1);
  assign dur_inc     = (fs_tick && dur_cnt != '1) ? dur_cnt + DUR_W'(1) : dur_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      match_cnt  <= '0;
      prev_pitch <= '0;
      prev_valid <= 1'b0;
      ref_pitch  <= '0;
      dur_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      match_cnt  <= match_nxt;
      prev_pitch <= prev_pitch_nxt;
      prev_valid <= prev_valid_nxt;
      ref_pitch  <= ref_pitch_nxt;
      dur_cnt    <= dur_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    match_nxt      = match_cnt;
    prev_pitch_nxt = prev_pitch;
    prev_valid_nxt = prev_valid;
    ref_pitch_nxt  = ref_pitch;
    dur_nxt        = dur_inc;
    ev             = 1'b0;
    case (state)
      ST_IDLE: begin
        dur_nxt = '0;
        if (crossing) begin
          state_nxt      = ST_ACQUIRE;
          match_nxt      = '0;
          prev_valid_nxt = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (crossing) begin
          prev_pitch_nxt = pitch;
          prev_valid_nxt = 1'b1;
          if (prev_valid && pitch_close(32'(pitch), 32'(prev_pitch), PITCH_TOL)) begin
            match_nxt = match_inc;
            if (match_inc == MATCH_W'(LOCK_EFF - 1)) begin
              state_nxt     = ST_LOCKED;
              ref_pitch_nxt = pitch;
            end
          end else begin
            match_nxt = '0;
          end
        end else if (timeout) begin
          state_nxt = ST_IDLE;
          dur_nxt   = '0;
        end
      end
      ST_LOCKED: begin
        if (crossing) begin
          // An off-pitch period ends this note and seeds the next acquisition.
          if (!pitch_close(32'(pitch), 32'(ref_pitch), PITCH_TOL)) begin
            ev             = 1'b1;
            state_nxt      = ST_ACQUIRE;
            prev_pitch_nxt = pitch;
            prev_valid_nxt = 1'b1;
            match_nxt      = '0;
            dur_nxt        = '0;
          end
        end else if (timeout) begin
          ev        = 1'b1;
          state_nxt = ST_IDLE;
          dur_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        dur_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_valid    <= 1'b0;
      note_pitch    <= '0;
      note_idx      <= '0;
      note_duration <= '0;
      tone_active   <= 1'b0;
    end else begin
      note_valid  <= ev;
      tone_active <= (state_nxt == ST_LOCKED);
      if (ev) begin
        note_pitch    <= ref_pitch;
        note_idx      <= note_index(32'(ref_pitch), PITCH_TOL);
        note_duration <= dur_inc;
      end
    end
  end

endmodule
